id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding, directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID and resolves RAW hazards by forwarding from MEM/WB.
- Detects load-use hazards and inserts a bubble.
- Drives the ALU's SrcA, SrcB and 4-bit Operation code.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU operation code width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all EX registers (downstream not ready)
flush  in  1  squash the ID instruction (taken branch/jump)
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_WIDTH  instruction PC
id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_alu_src  in  1  1: SrcB = immediate
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM/WB
mem_reg_write, wb_reg_write  in  1  MEM/WB will write back
mem_result, wb_result  in  DATA_WIDTH  MEM/WB forwarding values
SrcA, SrcB  out  DATA_WIDTH  to ALU
Operation  out  OPCODE_LENGTH  to ALU
ex_store_data  out  DATA_WIDTH  forwarded rs2, for stores
ex_pc  out  DATA_WIDTH  registered PC
ex_rd  out  REG_ADDR_W  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
load_use_stall  out  1  combinational; upstream must hold PC and IF/ID

Behaviour:
- Reset (asynchronous, active-high): every EX register clears to 0. ex_valid=0, all control bits 0, Operation=4'b0000, ex_rd=0, ex_pc=0, registered operands 0. SrcA/SrcB are then 0 unless MEM/WB forwarding matches.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd). Purely combinational.
- bubble = flush | load_use_stall.
- Register update priority per clock edge: reset > flush > stall > load_use_stall > load.
  - flush: EX loads the bubble (all fields 0), even if stall=1.
  - stall (no flush): all EX registers hold. load_use_stall is ignored while stall=1.
  - load_use_stall: EX loads the bubble.
  - otherwise: EX loads all id_* fields. ex_valid=id_valid; control bits are ANDed with id_valid.
- Latency: one cycle from ID inputs to registered fields.
- Forwarding is combinational on the registered rs1/rs2 and is re-evaluated every cycle, including stall cycles.
  - fwdA = mem_result if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - else fwdA = wb_result if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - else fwdA = registered rs1 data.
  - fwdB uses the same rule on ex_rs2. MEM always wins over WB.
  - x0 is never forwarded.
- Operand outputs:
  - SrcA = fwdA.
  - SrcB = ex_alu_src ? ex_imm : fwdB.
  - ex_store_data = fwdB, regardless of alu_src.
  - Operation = registered id_alu_op. Bubble gives 4'b0000 (AND), which is side-effect free.
- No arithmetic is performed here; widths pass through unchanged.

Decomposition:
- Shared package riscv_pkg:
  - ALU opcode constants: AND=0000, OR=0001, ADD=0010, SLL=0100, SRL=0101, XOR=0110, SRA=0111, EQ=1000, NE=1001, LTU=1010, GEU=1011, SLT=1100, SUB=1101.
  - struct id_ex_t bundling the registered fields.
  - REG_ADDR_W.
- Sub-module forward_unit: combinational; inputs ex_rs, mem/wb rd/we/result and reg data; output selected operand. Instantiated twice (A, B).

Test Plan:
- Reset mid-operation: assert reset asynchronously with ex_valid=1 -> ex_valid, ex_reg_write and Operation go to 0 immediately, without waiting for a clock edge.
- Plain load: id_rs1_data=5, id_imm=7, id_alu_src=1, id_alu_op=0010, id_valid=1 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- Forward priority: ex_rs1=3; mem_rd=3/mem_result=0xAA; wb_rd=3/wb_result=0xBB, both writing -> SrcA=0xAA. Drop mem_reg_write -> SrcA=0xBB. Set mem_rd=wb_rd=0 -> SrcA=registered data.
- Load-use: EX holds lw x4 (mem_read=1, rd=4); ID instruction has rs2=4 -> load_use_stall=1, next EX is a bubble (ex_valid=0). With ex_rd=0 instead -> load_use_stall=0.
- Stall vs flush: stall=1 for 3 cycles -> EX fields hold, SrcA tracks a changing mem_result on match. stall=1 and flush=1 together -> bubble loaded.
- Store data: id_alu_src=1, id_mem_write=1, rs2 matches wb_rd, wb_result=0x1234 -> ex_store_data=0x1234, SrcB=immediate.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
//============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the ID/EX operand stage: ALU opcode
//               encodings, register index width and the ID/EX pipeline
//               register bundle.
// Revision    : 1.0 - initial release
//============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    // ALU operation codes understood by the EX-stage ALU
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_NE  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_LTU = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_GEU = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b1101;

    // Everything the EX stage remembers about the instruction it holds.
    // An all-zero value is a bubble (invalid, no side effects, ALU_AND).
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
    } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
//============================================================================
// Module      : forward_unit
// Description : Combinational operand bypass. Selects the MEM result, the WB
//               result or the latched register-file value for one EX source
//               register. MEM is younger than WB and therefore wins; x0 is
//               never bypassed.
// Ports       : ex_rs_i       source register index held in EX
//               mem_*_i       MEM-stage destination, write enable, value
//               wb_*_i        WB-stage destination, write enable, value
//               reg_data_i    register-file value latched at ID
//               operand_o     selected operand
// Revision    : 1.0 - initial release
//============================================================================
module forward_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_we_i,
    input  logic [DATA_WIDTH-1:0] mem_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_we_i,
    input  logic [DATA_WIDTH-1:0] wb_result_i,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    output logic [DATA_WIDTH-1:0] operand_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    assign wb_hit  = wb_we_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);

    always_comb begin
        operand_o = reg_data_i;
        if (mem_hit) begin
            operand_o = mem_result_i;
        end else if (wb_hit) begin
            operand_o = wb_result_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
//============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register with MEM/WB operand forwarding and
//               load-use hazard detection, feeding the EX-stage ALU.
// Ports       : clk, reset           clock / asynchronous active-high reset
//               stall, flush         hold EX / squash the ID instruction
//               id_*                 decoded instruction from ID
//               mem_*, wb_*          forwarding sources from MEM and WB
//               SrcA, SrcB, Operation  ALU operands and op code
//               ex_store_data        forwarded rs2 for stores
//               ex_pc, ex_rd, ex_valid, ex_reg_write, ex_mem_read,
//               ex_mem_write         registered instruction fields
//               load_use_stall       combinational hold request to IF/ID
// Revision    : 1.0 - initial release
//============================================================================
module id_ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic [REG_ADDR_W-1:0]    mem_rd,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic                     mem_reg_write,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     load_use_stall
);

    import riscv_pkg::*;

    id_ex_t                  ex_q;
    id_ex_t                  ex_d;
    logic [DATA_WIDTH-1:0]   fwd_a;
    logic [DATA_WIDTH-1:0]   fwd_b;

    // A load in EX cannot supply its data until MEM, so a dependent
    // instruction in ID must wait one cycle behind a bubble.
    assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                            id_valid &&
                            ((id_rs1 == ex_q.rd) || (id_rs2 == ex_q.rd));

    // Priority: flush > stall > load-use bubble > normal load.
    // Flush wins over stall so a squashed instruction never survives a hold.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d        = '0;
            ex_d.alu_op = ALU_AND;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d        = '0;
            ex_d.alu_op = ALU_AND;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.mem_read  = id_mem_read  & id_valid;
            ex_d.mem_write = id_mem_write & id_valid;
            ex_d.alu_src   = id_alu_src;
            ex_d.alu_op    = id_alu_op;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.pc        = id_pc;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_rs_i      (ex_q.rs1),
        .mem_rd_i     (mem_rd),
        .mem_we_i     (mem_reg_write),
        .mem_result_i (mem_result),
        .wb_rd_i      (wb_rd),
        .wb_we_i      (wb_reg_write),
        .wb_result_i  (wb_result),
        .reg_data_i   (ex_q.rs1_data),
        .operand_o    (fwd_a)
    );

    forward_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_rs_i      (ex_q.rs2),
        .mem_rd_i     (mem_rd),
        .mem_we_i     (mem_reg_write),
        .mem_result_i (mem_result),
        .wb_rd_i      (wb_rd),
        .wb_we_i      (wb_reg_write),
        .wb_result_i  (wb_result),
        .reg_data_i   (ex_q.rs2_data),
        .operand_o    (fwd_b)
    );

    assign SrcA          = fwd_a;
    assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_b;
    // Stores always need the real rs2 value, even when SrcB carries the offset
    assign ex_store_data = fwd_b;
    assign Operation     = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rd         = ex_q.rd;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule
`default_nettype wire
